// File: rtl/host_tag_pkg.sv
// Shared types and default sizing for the host tag manager.
package host_tag_pkg;

   localparam int unsigned NTAGS_DEF      = 32;
   localparam int unsigned NSTRMS_DEF     = 64;
   localparam int unsigned ADDR_WIDTH_DEF = 64;
   localparam int unsigned CACHE_LINE_DEF = 128;

   typedef logic [$clog2(NTAGS_DEF)-1:0]  tag_t;
   typedef logic [$clog2(NSTRMS_DEF)-1:0] sid_t;

   // Tagged host command payload at default sizing.
   typedef struct packed {
      tag_t                      tag;
      logic [ADDR_WIDTH_DEF-1:0] ea;
   } cmd_t;

endpackage

// File: rtl/host_tag_alloc.sv
// Free-tag vector, lowest-free-tag encoder and in-flight counter.
module host_tag_alloc
   import host_tag_pkg::*;
#(
   parameter  int unsigned ntags       = NTAGS_DEF,
   localparam int unsigned ntags_width = $clog2(ntags)
) (
   input  logic                   clk,
   input  logic                   rst_n,
   input  logic                   alloc_en,
   output logic                   alloc_v_c,
   output logic [ntags_width-1:0] alloc_tag_c,
   input  logic                   free_en,
   input  logic [ntags_width-1:0] free_tag,
   output logic                   free_stray_c,
   output logic [ntags_width:0]   outstanding
);

   logic [ntags-1:0] free_q;
   logic             free_ok_c;

   // Lowest set bit wins: scan downward so the last hit is the smallest index.
   always_comb begin
      alloc_tag_c = '0;
      for (int i = int'(ntags) - 1; i >= 0; i--) begin
         if (free_q[i]) alloc_tag_c = ntags_width'(i);
      end
   end

   assign alloc_v_c    = |free_q;
   assign free_stray_c = free_q[free_tag];
   assign free_ok_c    = free_en && !free_stray_c;

   // Allocated and freed tags are always distinct, so both updates may land together.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         free_q <= '1;
      end else begin
         if (alloc_en)  free_q[alloc_tag_c] <= 1'b0;
         if (free_ok_c) free_q[free_tag]    <= 1'b1;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         outstanding <= '0;
      end else begin
         case ({alloc_en, free_ok_c})
            2'b10:   outstanding <= outstanding + (ntags_width+1)'(1);
            2'b01:   outstanding <= outstanding - (ntags_width+1)'(1);
            default: outstanding <= outstanding;
         endcase
      end
   end

endmodule

// File: rtl/host_tag_ctrl.sv
// Host tag manager: tags L2 line requests for the host and maps tagged responses back to streams.
// Optional build macro HOST_TAG_ALIGN_CHECK_EN: line-align command addresses and flag misaligned requests.
module host_tag_ctrl
   import host_tag_pkg::*;
#(
   parameter  int unsigned addr_width       = ADDR_WIDTH_DEF,
   parameter  int unsigned cache_line       = CACHE_LINE_DEF,
   parameter  int unsigned nstrms           = NSTRMS_DEF,
   parameter  int unsigned ntags            = NTAGS_DEF,
   localparam int unsigned cache_line_width = $clog2(cache_line),
   localparam int unsigned nstrms_width     = $clog2(nstrms),
   localparam int unsigned ntags_width      = $clog2(ntags)
) (
   input  logic                    clk,
   input  logic                    reset,
   input  logic                    i_req_v,
   output logic                    i_req_r,
   input  logic [nstrms_width-1:0] i_req_sid,
   input  logic [addr_width-1:0]   i_req_ea,
   output logic                    o_cmd_v,
   input  logic                    o_cmd_r,
   output logic [ntags_width-1:0]  o_cmd_tag,
   output logic [addr_width-1:0]   o_cmd_ea,
   input  logic                    i_hrsp_v,
   output logic                    i_hrsp_r,
   input  logic [ntags_width-1:0]  i_hrsp_tag,
   output logic                    o_rsp_v,
   input  logic                    o_rsp_r,
   output logic [nstrms_width-1:0] o_rsp_sid,
   output logic [ntags_width:0]    o_outstanding,
`ifdef HOST_TAG_ALIGN_CHECK_EN
   output logic                    o_err_align,
`endif
   output logic                    o_err_tag
);

   logic                        run_q;
   logic                        alloc_v_c;
   logic [ntags_width-1:0]      alloc_tag_c;
   logic                        stray_c;
   logic                        req_hs_c;
   logic                        hrsp_hs_c;
   logic [cache_line_width-1:0] line_off_c;
   logic [nstrms_width-1:0]     sid_tbl [ntags];

   // Holds request ready low through reset and releases it the cycle after.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) run_q <= 1'b0;
      else        run_q <= 1'b1;
   end

   assign i_req_r   = run_q && alloc_v_c && (!o_cmd_v || o_cmd_r);
   assign i_hrsp_r  = !o_rsp_v || o_rsp_r;
   assign req_hs_c  = i_req_v && i_req_r;
   assign hrsp_hs_c = i_hrsp_v && i_hrsp_r;

   host_tag_alloc #(
      .ntags (ntags)
   ) u_alloc (
      .clk          (clk),
      .rst_n        (reset),
      .alloc_en     (req_hs_c),
      .alloc_v_c    (alloc_v_c),
      .alloc_tag_c  (alloc_tag_c),
      .free_en      (hrsp_hs_c),
      .free_tag     (i_hrsp_tag),
      .free_stray_c (stray_c),
      .outstanding  (o_outstanding)
   );

`ifdef HOST_TAG_ALIGN_CHECK_EN
   assign line_off_c = '0;
`else
   assign line_off_c = i_req_ea[cache_line_width-1:0];
`endif

   // Command output register; a new handshake may reload it in the same cycle it drains.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         o_cmd_v   <= 1'b0;
         o_cmd_tag <= '0;
         o_cmd_ea  <= '0;
      end else if (req_hs_c) begin
         o_cmd_v   <= 1'b1;
         o_cmd_tag <= alloc_tag_c;
         o_cmd_ea  <= {i_req_ea[addr_width-1:cache_line_width], line_off_c};
      end else if (o_cmd_r) begin
         o_cmd_v   <= 1'b0;
      end
   end

   always_ff @(posedge clk) begin
      if (req_hs_c) sid_tbl[alloc_tag_c] <= i_req_sid;
   end

   // Response output register; stray tags are dropped and only raise the sticky error.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         o_rsp_v   <= 1'b0;
         o_rsp_sid <= '0;
         o_err_tag <= 1'b0;
      end else begin
         if (hrsp_hs_c && !stray_c) begin
            o_rsp_v   <= 1'b1;
            o_rsp_sid <= sid_tbl[i_hrsp_tag];
         end else if (o_rsp_r) begin
            o_rsp_v   <= 1'b0;
         end
         if (hrsp_hs_c && stray_c) o_err_tag <= 1'b1;
      end
   end

`ifdef HOST_TAG_ALIGN_CHECK_EN
   always_ff @(posedge clk or negedge reset) begin
      if (!reset)                                            o_err_align <= 1'b0;
      else if (req_hs_c && |i_req_ea[cache_line_width-1:0]) o_err_align <= 1'b1;
   end
`endif

endmodule

// File: tb/tb_host_tag_ctrl.sv
// Scoreboard bench for host_tag_ctrl: stimulus pushes expected commands/responses, a monitor pops and compares.
module tb_host_tag_ctrl;
   import host_tag_pkg::*;

   logic        clk;
   logic        reset;
   logic        i_req_v;
   logic        i_req_r;
   sid_t        i_req_sid;
   logic [63:0] i_req_ea;
   logic        o_cmd_v;
   logic        o_cmd_r;
   tag_t        o_cmd_tag;
   logic [63:0] o_cmd_ea;
   logic        i_hrsp_v;
   logic        i_hrsp_r;
   tag_t        i_hrsp_tag;
   logic        o_rsp_v;
   logic        o_rsp_r;
   sid_t        o_rsp_sid;
   logic [5:0]  o_outstanding;
   logic        o_err_tag;
`ifdef HOST_TAG_ALIGN_CHECK_EN
   logic        o_err_align;
`endif

   int   vectors    = 0;
   int   miscompares = 0;
   cmd_t cmd_q[$];
   sid_t rsp_q[$];

   host_tag_ctrl dut (
      .clk           (clk),
      .reset         (reset),
      .i_req_v       (i_req_v),
      .i_req_r       (i_req_r),
      .i_req_sid     (i_req_sid),
      .i_req_ea      (i_req_ea),
      .o_cmd_v       (o_cmd_v),
      .o_cmd_r       (o_cmd_r),
      .o_cmd_tag     (o_cmd_tag),
      .o_cmd_ea      (o_cmd_ea),
      .i_hrsp_v      (i_hrsp_v),
      .i_hrsp_r      (i_hrsp_r),
      .i_hrsp_tag    (i_hrsp_tag),
      .o_rsp_v       (o_rsp_v),
      .o_rsp_r       (o_rsp_r),
      .o_rsp_sid     (o_rsp_sid),
      .o_outstanding (o_outstanding),
`ifdef HOST_TAG_ALIGN_CHECK_EN
      .o_err_align   (o_err_align),
`endif
      .o_err_tag     (o_err_tag)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   // Monitor: every accepted output beat is matched against the head of its queue.
   always @(negedge clk) begin
      cmd_t exp_c;
      sid_t exp_s;
      if (o_cmd_v && o_cmd_r) begin
         vectors++;
         if (cmd_q.size() == 0) begin
            miscompares++;
            $display("FAIL cmd_unexpected: got tag=%0d ea=%h, none expected", o_cmd_tag, o_cmd_ea);
         end else begin
            exp_c = cmd_q.pop_front();
            if (o_cmd_tag !== exp_c.tag || o_cmd_ea !== exp_c.ea) begin
               miscompares++;
               $display("FAIL cmd: got tag=%0d ea=%h, expected tag=%0d ea=%h",
                        o_cmd_tag, o_cmd_ea, exp_c.tag, exp_c.ea);
            end
         end
      end
      if (o_rsp_v && o_rsp_r) begin
         vectors++;
         if (rsp_q.size() == 0) begin
            miscompares++;
            $display("FAIL rsp_unexpected: got sid=%0d, none expected", o_rsp_sid);
         end else begin
            exp_s = rsp_q.pop_front();
            if (o_rsp_sid !== exp_s) begin
               miscompares++;
               $display("FAIL rsp: got sid=%0d, expected sid=%0d", o_rsp_sid, exp_s);
            end
         end
      end
   end

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      vectors++;
      if (act !== exp) begin
         miscompares++;
         $display("FAIL %s: got %0h, expected %0h", name, act, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic req(input int sid, input logic [63:0] ea, input int exp_tag);
      i_req_v   = 1'b1;
      i_req_sid = sid_t'(sid);
      i_req_ea  = ea;
      cmd_q.push_back('{tag: tag_t'(exp_tag), ea: ea});
   endtask

   task automatic hrsp(input int tag, input int exp_sid);
      i_hrsp_v   = 1'b1;
      i_hrsp_tag = tag_t'(tag);
      rsp_q.push_back(sid_t'(exp_sid));
   endtask

   task automatic apply_reset(input string name);
      reset = 1'b0;
      step();
      chk({name, "_req_r"},  64'(i_req_r), 64'd0);
      chk({name, "_cmd_v"},  64'(o_cmd_v), 64'd0);
      chk({name, "_rsp_v"},  64'(o_rsp_v), 64'd0);
      chk({name, "_outst"},  64'(o_outstanding), 64'd0);
      chk({name, "_errtag"}, 64'(o_err_tag), 64'd0);
      cmd_q.delete();
      rsp_q.delete();
      o_cmd_r = 1'b1;
      o_rsp_r = 1'b1;
      step();
      reset = 1'b1;
      step();
      chk({name, "_req_r_after"}, 64'(i_req_r), 64'd1);
   endtask

   initial begin
      reset      = 1'b0;
      i_req_v    = 1'b0;
      i_req_sid  = '0;
      i_req_ea   = '0;
      i_hrsp_v   = 1'b0;
      i_hrsp_tag = '0;
      o_cmd_r    = 1'b1;
      o_rsp_r    = 1'b1;
      step();
      chk("rst_cmd_tag", 64'(o_cmd_tag), 64'd0);
      chk("rst_cmd_ea",  o_cmd_ea,       64'd0);
      chk("rst_rsp_sid", 64'(o_rsp_sid), 64'd0);
      apply_reset("rst");

      // Single request round trip.
      req(5, 64'h1000, 0);
      step();
      i_req_v = 1'b0;
      chk("single_outst1", 64'(o_outstanding), 64'd1);
      hrsp(0, 5);
      step();
      i_hrsp_v = 1'b0;
      chk("single_outst0", 64'(o_outstanding), 64'd0);
`ifdef HOST_TAG_ALIGN_CHECK_EN
      chk("single_align0", 64'(o_err_align), 64'd0);
`endif

      // Fill all 32 tags, 33rd request must stall until tag 7 returns.
      for (int i = 0; i < 32; i++) begin
         chk("fill_req_r", 64'(i_req_r), 64'd1);
         req(i, 64'h2000 + 64'(i) * 64'h80, i);
         step();
      end
      i_req_v   = 1'b1;
      i_req_sid = sid_t'(40);
      i_req_ea  = 64'h9000;
      chk("full_outst", 64'(o_outstanding), 64'd32);
      chk("full_req_r", 64'(i_req_r), 64'd0);
      step(); step(); step();
      chk("full_req_r_hold", 64'(i_req_r), 64'd0);
      hrsp(7, 7);
      step();
      i_hrsp_v = 1'b0;
      chk("reuse_req_r", 64'(i_req_r), 64'd1);
      cmd_q.push_back('{tag: tag_t'(7), ea: 64'h9000});
      step();
      i_req_v = 1'b0;
      chk("reuse_outst", 64'(o_outstanding), 64'd32);

      // Tag freed this cycle is not selectable this cycle; then alloc+free together.
      req(50, 64'hA000, 11);
      hrsp(11, 11);
      chk("samecyc_req_r", 64'(i_req_r), 64'd0);
      step();
      i_hrsp_v = 1'b0;
      chk("samecyc_req_r_next", 64'(i_req_r), 64'd1);
      hrsp(10, 10);
      step();
      i_req_v  = 1'b0;
      i_hrsp_v = 1'b0;
      chk("allocfree_outst", 64'(o_outstanding), 64'd31);
      req(51, 64'hB000, 10);
      step();
      i_req_v = 1'b0;
      chk("allocfree_outst2", 64'(o_outstanding), 64'd32);

      // Stray response on a free tag.
      hrsp(3, 3);
      step();
      chk("stray_pre_err", 64'(o_err_tag), 64'd0);
      i_hrsp_v   = 1'b1;
      i_hrsp_tag = tag_t'(3);
      step();
      i_hrsp_v = 1'b0;
      chk("stray_err",   64'(o_err_tag), 64'd1);
      chk("stray_rsp_v", 64'(o_rsp_v), 64'd0);
      chk("stray_outst", 64'(o_outstanding), 64'd31);
      step(); step(); step(); step();
      chk("stray_err_sticky", 64'(o_err_tag), 64'd1);

      // Back-pressure on both outputs for 10 cycles, then drain.
      o_cmd_r = 1'b0;
      o_rsp_r = 1'b0;
      req(60, 64'hC000, 3);
      hrsp(20, 20);
      step();
      i_req_v    = 1'b1;
      i_req_sid  = sid_t'(61);
      i_req_ea   = 64'hD000;
      i_hrsp_v   = 1'b1;
      i_hrsp_tag = tag_t'(21);
      for (int i = 0; i < 10; i++) begin
         chk("stall_cmd_tag", 64'(o_cmd_tag), 64'd3);
         chk("stall_cmd_ea",  o_cmd_ea,       64'hC000);
         chk("stall_rsp_sid", 64'(o_rsp_sid), 64'd20);
         chk("stall_readies", 64'({i_req_r, i_hrsp_r, o_cmd_v, o_rsp_v}), 64'b0011);
         step();
      end
      cmd_q.push_back('{tag: tag_t'(20), ea: 64'hD000});
      rsp_q.push_back(sid_t'(21));
      o_cmd_r = 1'b1;
      o_rsp_r = 1'b1;
      step();
      i_req_v  = 1'b0;
      i_hrsp_v = 1'b0;
      step(); step();
      chk("drain_outst", 64'(o_outstanding), 64'd31);

      // Reset with 12 tags outstanding and both outputs held.
      apply_reset("rst2");
      for (int i = 0; i < 12; i++) begin
         chk("r12_req_r", 64'(i_req_r), 64'd1);
         req(20 + i, 64'h4000 + 64'(i) * 64'h80, i);
         step();
      end
      i_req_v = 1'b0;
      chk("r12_outst", 64'(o_outstanding), 64'd12);
      o_cmd_r = 1'b0;
      o_rsp_r = 1'b0;
      hrsp(4, 24);
      step();
      i_hrsp_v = 1'b0;
      chk("r12_held", 64'({o_cmd_v, o_rsp_v}), 64'b11);
      chk("r12_outst11", 64'(o_outstanding), 64'd11);
      apply_reset("rst3");
      req(9, 64'hE000, 0);
      step();
      i_req_v = 1'b0;
      step(); step();
      chk("post_rst_outst", 64'(o_outstanding), 64'd1);

`ifdef HOST_TAG_ALIGN_CHECK_EN
      // Misaligned address is line-aligned on the command and flagged.
      req(2, 64'h1000, 1);
      i_req_ea = 64'h1004;
      step();
      i_req_v = 1'b0;
      step();
      chk("align_err", 64'(o_err_align), 64'd1);
`endif

      step(); step(); step();
      chk("cmd_q_empty", 64'(cmd_q.size()), 64'd0);
      chk("rsp_q_empty", 64'(rsp_q.size()), 64'd0);
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
